arb_rr8: RTL and testbench
==========================

# arb_rr8

Round-robin arbiter sharing a single downstream resource among eight requesters. Produces a registered one-hot grant plus its 3-bit encoded index, the same 8-to-3 mapping the team's encoder uses (bit k → index k). Grants are held until the owner drops its request. Sits between requester-side logic and the encoder-indexed datapath select.

## Interface

Parameters:
- `MAX_HOLD`, default 15: maximum consecutive grant cycles per owner, range 1–255. Used only when `ARB_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `en`  in  1  arbiter enable; 0 blocks new grants and releases any held grant.
- `req`  in  8  request vector; bit k is requester k. A requester holds its bit high for as long as it wants the resource.
- `gnt`  out  8  registered one-hot grant, or all zeros.
- `idx`  out  3  registered encoded index of the granted bit. Holds its last value while `valid`=0.
- `valid`  out  1  registered; 1 while a grant is held. Always equals |`gnt`.
- `tout`  out  1  registered one-cycle pulse on a forced (timeout) release.

## Operation

- States:
  - IDLE: no owner.
  - GRANT: owner is `idx`.
- Internal pointer `ptr` (3 bits) marks the highest-priority requester for the next arbitration.
- IDLE, `en`=1 and `req`≠0:
  - Winner is the first set bit scanning `ptr`, `ptr`+1, …, 7, 0, …, `ptr`−1 (mod 8).
  - At the next edge: `gnt`=one-hot(winner), `idx`=winner, `valid`=1, state → GRANT.
- IDLE, `en`=0 or `req`=0: stay in IDLE; outputs remain zero.
- GRANT, `en`=1 and `req[idx]`=1: hold; all outputs unchanged.
- GRANT, `req[idx]`=0 or `en`=0 (release):
  - At the next edge: `gnt`=0, `valid`=0, `ptr`=`idx`+1 (mod 8, so 7 wraps to 0), state → IDLE.
  - `idx` keeps the released value.
- Requests from other bits during GRANT are ignored. No preemption.
- Multi-bit `req` is legal. Arbitration always yields exactly one grant.
- `gnt` is never multi-hot. `valid`, `gnt` and `idx` never disagree.
- Reset values: state IDLE, `gnt`=0, `idx`=0, `valid`=0, `tout`=0, `ptr`=0, hold counter 0.
- Reset asserted mid-grant: all of the above on the next edge. No release pointer update.

## Timing

- Grant latency: `req` sampled at edge N in IDLE → `gnt`/`valid` high after edge N (visible in cycle N+1).
- Release latency: `req[idx]` low sampled at edge M → `gnt`=0 after edge M.
- Back-to-back hand-off between owners: exactly one idle cycle with `valid`=0.
  - Example: release at edge M, re-arbitration at edge M+1, new grant visible after edge M+1.
- Single requester held high continuously: it keeps the grant indefinitely (timeout disabled).
- Owner drops and re-raises `req` within one cycle: the release is still honoured. It competes again using the advanced `ptr`.
- Inputs are synchronous to `clk`. No combinational path from inputs to outputs.

## Configuration

- `ARB_TIMEOUT_EN` defined:
  - An 8-bit hold counter clears on grant and increments each GRANT cycle.
  - When the owner has held the grant for `MAX_HOLD` cycles, the next edge performs a release regardless of `req`: `ptr`=`idx`+1, `tout`=1 for one cycle.
  - A forced release coinciding with a voluntary release counts as voluntary: `tout`=0.
- `ARB_TIMEOUT_EN` not defined:
  - No counter is built and `tout` is tied to 0.
  - Releases occur only on a `req` drop or `en`=0.

## Test plan

- Reset then idle: `rst`=1 for 2 cycles, `req`=0 → `gnt`=0, `idx`=0, `valid`=0, `tout`=0 throughout.
- Single request: `en`=1, `req`=8'h20 → next cycle `gnt`=8'h20, `idx`=5, `valid`=1. Drop `req` → `gnt`=0 one cycle later; `ptr`=6.
- Rotation: `req`=8'hFF held, each owner drops its bit for one cycle after 3 grant cycles → grant sequence idx 0,1,2,…,7,0 with one `valid`=0 cycle between owners.
- Wrap priority: `ptr`=6 (after idx 5 released), `req`=8'h09 → grant `idx`=0 (scan 6,7,0), not 3.
- Enable drop: hold grant on idx 2, then `en`=0 → `gnt`=0 next cycle; with `en` still 0 and `req`=8'hFF, no grant. Raise `en` → grant `idx`=3.
- With `ARB_TIMEOUT_EN`, `MAX_HOLD`=4: `req`=8'h03 held → idx 0 granted for 4 cycles, `tout` pulses, idle cycle, then idx 1 granted. Also reset mid-grant → all outputs 0 next cycle.

Source files
------------

// File: rtl/arb_rr8.sv
// arb_rr8: eight-way round-robin arbiter with a registered one-hot grant and
// its encoded index (bit k -> index k). An owner keeps the grant until it
// drops its request or the arbiter is disabled.
// Optional feature: define ARB_TIMEOUT_EN to force a release after MAX_HOLD
// consecutive grant cycles, signalled by a one-cycle tout pulse.
module arb_rr8 #(
  parameter int MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] idx,
  output logic       valid,
  output logic       tout
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] idx_q, idx_d;
  logic       valid_q, valid_d;

  logic [7:0] rot_s;
  logic [2:0] pos_s;
  logic [2:0] win_s;
  logic       arb_s;
  logic       rel_vol_s;
  logic       rel_force_s;
  logic       rel_s;

  // Out-of-range hold limits are rejected when the design is elaborated.
  if (MAX_HOLD < 32'sd1 || MAX_HOLD > 32'sd255) begin : g_bad_max_hold
    $error("arb_rr8: MAX_HOLD must lie in 1..255");
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_q, hold_d;
  logic       tout_q, tout_d;
  assign rel_force_s = (hold_q == HOLD_LAST);
`else
  assign rel_force_s = 1'b0;
`endif

  // Rotate the request vector so that bit 0 corresponds to the pointer position.
  assign rot_s = (req >> ptr_q) | (req << (4'd8 - {1'b0, ptr_q}));

  // First set bit of the rotated vector, mapped back to a requester index.
  always_comb begin
    pos_s = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      pos_s = rot_s[i] ? 3'(i) : pos_s;
    end
    win_s = ptr_q + pos_s;
  end

  assign arb_s     = en && (req != 8'h00);
  assign rel_vol_s = !en || !req[idx_q];
  assign rel_s     = rel_vol_s || rel_force_s;

  // State register plus all registered outputs and the priority pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 3'd0;
      gnt_q   <= 8'h00;
      idx_q   <= 3'd0;
      valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= 8'd0;
      tout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= hold_d;
      tout_q  <= tout_d;
`endif
    end
  end

  // Next-state decision: grant from idle, return to idle on any release.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (arb_s) state_d = S_GRANT;
        else       state_d = S_IDLE;
      end
      S_GRANT: begin
        if (rel_s) state_d = S_IDLE;
        else       state_d = S_GRANT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and pointer updates that accompany each state transition.
  always_comb begin
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;
`ifdef ARB_TIMEOUT_EN
    hold_d  = hold_q;
    tout_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (arb_s) begin
          gnt_d   = 8'h01 << win_s;
          idx_d   = win_s;
          valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_d  = 8'd0;
`endif
        end else begin
          gnt_d   = 8'h00;
          valid_d = 1'b0;
        end
      end
      S_GRANT: begin
        if (rel_s) begin
          gnt_d   = 8'h00;
          valid_d = 1'b0;
          ptr_d   = idx_q + 3'd1;
`ifdef ARB_TIMEOUT_EN
          // A coincident voluntary release takes precedence: no pulse.
          tout_d  = rel_force_s && !rel_vol_s;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
          hold_d  = hold_q + 8'd1;
`endif
          gnt_d   = gnt_q;
        end
      end
      default: begin
        gnt_d   = 8'h00;
        valid_d = 1'b0;
      end
    endcase
  end

  assign gnt   = gnt_q;
  assign idx   = idx_q;
  assign valid = valid_q;
`ifdef ARB_TIMEOUT_EN
  assign tout  = tout_q;
`else
  assign tout  = 1'b0;
`endif

endmodule

// File: tb/tb_arb_rr8.sv
// Bench for arb_rr8: a behavioural owner/pointer model checked every cycle,
// plus directed sequences with literal expectations.
module tb_arb_rr8;

`ifdef ARB_TIMEOUT_EN
  localparam int MH    = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int MH    = 15;
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] idx;
  logic       valid;
  logic       tout;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  arb_rr8 #(.MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt), .idx(idx), .valid(valid), .tout(tout)
  );

  always #5 clk = ~clk;

  // Model: owner (-1 = nobody), next-priority pointer, last index,
  // number of cycles the current owner has been visible, timeout pulse.
  typedef struct {
    int owner;
    int ptr;
    int idx;
    int hold;
    bit tout;
  } model_t;

  model_t m_q = '{-1, 0, 0, 0, 1'b0};

  function automatic model_t next_model(model_t m, logic r, logic e, logic [7:0] q);
    model_t n = m;
    bit vol, forced;
    n.tout = 1'b0;
    if (r) begin
      n = '{-1, 0, 0, 0, 1'b0};
    end else if (m.owner < 0) begin
      if (e && q != 8'h00) begin
        for (int i = 0; i < 8; i++) begin
          int k = (m.ptr + i) % 8;
          if (q[k] && n.owner < 0) begin
            n.owner = k;
            n.idx   = k;
            n.hold  = 1;
          end
        end
      end
    end else begin
      vol    = !e || !q[m.owner];
      forced = TO_EN && (m.hold >= MH);
      if (vol || forced) begin
        n.owner = -1;
        n.ptr   = (m.owner + 1) % 8;
        n.tout  = forced && !vol;
      end else begin
        n.hold = m.hold + 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk) m_q <= next_model(m_q, rst, en, req);

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("m_gnt",   gnt,  (m_q.owner >= 0) ? (8'h01 << m_q.owner) : 8'h00);
      check("m_idx",   {5'd0, idx}, 8'(m_q.idx));
      check("m_valid", {7'd0, valid}, {7'd0, (m_q.owner >= 0)});
      check("m_tout",  {7'd0, tout}, {7'd0, m_q.tout});
      check("onehot",  {7'd0, ($countones(gnt) <= 1)}, 8'h01);
      check("vld_or",  {7'd0, valid}, {7'd0, |gnt});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [7:0] g,
                            input logic [2:0] i, input logic v);
    check({name, "_gnt"},   gnt, g);
    check({name, "_idx"},   {5'd0, idx}, {5'd0, i});
    check({name, "_valid"}, {7'd0, valid}, {7'd0, v});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset then idle
    rst = 1'b1; en = 1'b0; req = 8'h00;
    tick();
    chk_on = 1'b1;
    tick();
    expect_out("reset", 8'h00, 3'd0, 1'b0);
    check("reset_tout", {7'd0, tout}, 8'h00);
    rst = 1'b0;
    tick();
    expect_out("idle", 8'h00, 3'd0, 1'b0);

    // Single request on bit 5, then release
    en = 1'b1; req = 8'h20;
    tick();
    expect_out("single", 8'h20, 3'd5, 1'b1);
    req = 8'h00;
    tick();
    expect_out("single_rel", 8'h00, 3'd5, 1'b0);

    // Pointer now 6: scan 6,7,0 picks 0 ahead of 3
    req = 8'h09;
    tick();
    expect_out("wrap", 8'h01, 3'd0, 1'b1);
    req = 8'h00;
    tick();
    expect_out("wrap_rel", 8'h00, 3'd0, 1'b0);

    // Rotation with all requesters active
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick();
      check("rot_idx", {5'd0, idx}, 8'(k % 8));
      check("rot_valid", {7'd0, valid}, 8'h01);
      tick();
      tick();
      req = 8'hFF & ~(8'h01 << (k % 8));
      tick();
      check("rot_gap", {7'd0, valid}, 8'h00);
      req = 8'hFF;
    end
    req = 8'h00;
    tick();

    // Enable drop releases and blocks grants
    do_reset();
    en = 1'b1; req = 8'h04;
    tick();
    expect_out("en_grant", 8'h04, 3'd2, 1'b1);
    req = 8'hFF;
    tick();
    expect_out("en_hold", 8'h04, 3'd2, 1'b1);
    en = 1'b0;
    tick();
    expect_out("en_drop", 8'h00, 3'd2, 1'b0);
    tick();
    expect_out("en_block", 8'h00, 3'd2, 1'b0);
    en = 1'b1;
    tick();
    expect_out("en_raise", 8'h08, 3'd3, 1'b1);
    req = 8'h00;
    tick();

    // Owner drops for one cycle and re-raises: pointer has advanced
    do_reset();
    req = 8'h01;
    tick();
    expect_out("rer_grant", 8'h01, 3'd0, 1'b1);
    req = 8'h00;
    tick();
    req = 8'h03;
    tick();
    expect_out("rer_next", 8'h02, 3'd1, 1'b1);
    req = 8'h00;
    tick();

`ifdef ARB_TIMEOUT_EN
    // Forced release after MAX_HOLD cycles
    do_reset();
    req = 8'h03;
    for (int c = 0; c < 4; c++) begin
      tick();
      expect_out("to_hold", 8'h01, 3'd0, 1'b1);
    end
    tick();
    expect_out("to_rel", 8'h00, 3'd0, 1'b0);
    check("to_pulse", {7'd0, tout}, 8'h01);
    tick();
    expect_out("to_next", 8'h02, 3'd1, 1'b1);
    check("to_clear", {7'd0, tout}, 8'h00);
`else
    // Single requester keeps the grant indefinitely
    do_reset();
    req = 8'h01;
    for (int c = 0; c < 20; c++) tick();
    expect_out("long_hold", 8'h01, 3'd0, 1'b1);
    req = 8'h03;
`endif

    // Reset asserted mid-grant
    tick();
    rst = 1'b1;
    tick();
    expect_out("mid_rst", 8'h00, 3'd0, 1'b0);
    check("mid_rst_tout", {7'd0, tout}, 8'h00);
    rst = 1'b0;
    req = 8'h00;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
